// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: capture FSM state encoding and channel geometry shared with the read side
package adc_capture_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    ARMED   = 4'b0010,
    CAPTURE = 4'b0100,
    DONE    = 4'b1000
  } cap_state_t;
  localparam int NCH_DEFAULT = 6;
  localparam int DW_DEFAULT  = 16;
endpackage

// File: rtl/trig_sync_edge.sv
// trig_sync_edge: 2-FF synchroniser for an async trigger plus a registered rising-edge pulse (i_trig in, o_pulse out)
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_trig,
  output logic o_pulse
);
  logic r_meta, r_sync, r_prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      r_meta  <= i_trig;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      o_pulse <= r_sync & ~r_prev;
    end
  end
endmodule

// File: rtl/capture_write_controller.sv
// capture_write_controller: arms, waits for a trigger, writes CAPTURE_LEN aligned samples into NCH FIFOs, holds full until drained
module capture_write_controller
  import adc_capture_pkg::*;
#(
  parameter int NCH         = NCH_DEFAULT,
  parameter int DW          = DW_DEFAULT,
  parameter int CAPTURE_LEN = 8192,
  parameter int CW          = $clog2(CAPTURE_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic              force_trig,
  input  logic              adc_valid,
  input  logic [NCH*DW-1:0] adc_data,
  input  logic [NCH-1:0]    fifo_full,
  input  logic [NCH-1:0]    fifo_empty,
  output logic [NCH-1:0]    fifo_wr_en,
  output logic [NCH*DW-1:0] fifo_din,
  output logic              full,
  output logic              busy,
  output logic              overflow,
  output logic [CW-1:0]     sample_count
);
  cap_state_t r_state, w_next;
  logic w_edge, w_evt, w_all_empty, w_arm_ok, w_take, w_block, w_write, w_last;
  trig_sync_edge u_trig (
    .clk    (clk),
    .rst    (rst),
    .i_trig (trig),
    .o_pulse(w_edge)
  );
  assign w_evt       = w_edge | force_trig;
  assign w_all_empty = &fifo_empty;
  assign w_arm_ok    = (r_state == IDLE) && arm && w_all_empty;
  assign w_take      = (r_state == CAPTURE) && adc_valid;
  // a full FIFO anywhere blocks the write on every channel so the channels stay aligned
  assign w_block     = w_take && |fifo_full;
  assign w_write     = w_take && !(|fifo_full);
  assign w_last      = w_write && (sample_count == CW'(CAPTURE_LEN - 1));
  assign busy        = (r_state != IDLE);
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_arm_ok ? ARMED : IDLE;
      ARMED:   w_next = w_evt ? CAPTURE : ARMED;
      CAPTURE: w_next = (w_block || w_last) ? DONE : CAPTURE;
      DONE:    w_next = w_all_empty ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      fifo_wr_en   <= '0;
      fifo_din     <= '0;
      full         <= 1'b0;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else begin
      r_state    <= w_next;
      fifo_wr_en <= {NCH{w_write}};
      if (w_write) fifo_din <= adc_data;
      if (w_arm_ok) sample_count <= '0;
      else if (w_write && sample_count < CW'(CAPTURE_LEN)) sample_count <= sample_count + 1'b1;
      overflow <= w_arm_ok ? 1'b0 : (overflow | w_block);
      // registered from next state, so full tracks DONE exactly
      full <= (w_next == DONE);
    end
  end
endmodule

// File: tb/tb_capture_write_controller.sv
// tb_capture_write_controller: scoreboard bench with a behavioural capture model and randomized stimulus
module tb_capture_write_controller;
  localparam int NCH = 6, DW = 16, LEN = 16, CW = $clog2(LEN + 1);
  logic clk, rst, arm, trig, force_trig, adc_valid;
  logic [NCH*DW-1:0] adc_data, fifo_din, exp_d;
  logic [NCH-1:0] fifo_full, fifo_empty, fifo_wr_en;
  logic full, busy, overflow;
  logic [CW-1:0] sample_count;
  logic [CW+2:0] act_s, exp_s;
  logic [NCH*DW-1:0] exp_q[$];
  int tests, fails, edge_cnt, wr_seen, rise_edge;
  bit lat_pending;
  int ph, m_cnt;
  bit m_ovf;
  logic [4:0] th;

  capture_write_controller #(.NCH(NCH), .DW(DW), .CAPTURE_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .force_trig(force_trig),
    .adc_valid(adc_valid), .adc_data(adc_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .full(full), .busy(busy),
    .overflow(overflow), .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  always @(posedge clk) begin
    #1;
    if (fifo_wr_en != '0) begin
      wr_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write wr_en=%h din=%h expected no write", fifo_wr_en, fifo_din);
      end else begin
        exp_d = exp_q.pop_front();
        if (fifo_wr_en != '1 || fifo_din != exp_d) begin
          fails++;
          $display("FAIL write_data wr_en=%h din=%h expected wr_en=3f din=%h", fifo_wr_en, fifo_din, exp_d);
        end
      end
      if (lat_pending) begin
        lat_pending = 1'b0;
        tests++;
        if (edge_cnt - rise_edge != 4) begin
          fails++;
          $display("FAIL trig_latency got %0d edges expected 4", edge_cnt - rise_edge);
        end
      end
    end
  end

  task automatic tick();
    bit evt;
    if (rst) begin
      ph = 0; m_cnt = 0; m_ovf = 0; th = '0;
    end else begin
      evt = force_trig | (th[2] & ~th[3]);
      case (ph)
        0: if (arm && fifo_empty == '1) begin ph = 1; m_cnt = 0; m_ovf = 0; end
        1: if (evt) ph = 2;
        2: if (adc_valid) begin
             if (fifo_full != '0) begin m_ovf = 1; ph = 3; end
             else begin
               exp_q.push_back(adc_data);
               m_cnt++;
               if (m_cnt == LEN) ph = 3;
             end
           end
        default: if (fifo_empty == '1) ph = 0;
      endcase
      th = {th[3:0], trig};
    end
    @(posedge clk);
    @(negedge clk);
    act_s = {full, busy, overflow, sample_count};
    exp_s = {ph == 3, ph != 0, m_ovf, CW'(m_cnt)};
    tests++;
    if (act_s != exp_s) begin
      fails++;
      $display("FAIL status full/busy/ovf/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
               full, busy, overflow, sample_count, exp_s[CW+2], exp_s[CW+1], exp_s[CW], exp_s[CW-1:0]);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic start_capture();
    fifo_empty = '1; arm = 1; tick();
    arm = 0; fifo_empty = '0; force_trig = 1; tick();
    force_trig = 0;
  endtask

  initial begin
    rst = 1; arm = 0; trig = 0; force_trig = 0; adc_valid = 0; adc_data = '0;
    fifo_full = '0; fifo_empty = '1; lat_pending = 0; rise_edge = 0;
    repeat (3) tick();
    check("reset_outputs", int'({fifo_wr_en, fifo_din, full, busy, overflow, sample_count} == '0), 1);
    rst = 0;
    tick();
    // nominal ramp capture, then a long undrained DONE
    wr_seen = 0;
    start_capture();
    for (int i = 0; i < 20; i++) begin
      adc_valid = 1; adc_data = {NCH{DW'(i)}}; tick();
    end
    adc_valid = 0;
    check("nominal_writes", wr_seen, LEN);
    check("nominal_full", int'(full), 1);
    repeat (200) tick();
    check("drain_hold_full", int'(full), 1);
    fifo_empty = '1; tick();
    check("drain_idle", int'({full, busy}), 0);
    // gapped valid
    wr_seen = 0;
    start_capture();
    for (int i = 0; i < 60; i++) begin
      adc_valid = (i % 3 == 0); adc_data = {$urandom, $urandom, $urandom}; tick();
    end
    adc_valid = 0;
    check("gapped_writes", wr_seen, LEN);
    check("gapped_count", int'(sample_count), LEN);
    fifo_empty = '1; tick();
    // arm refused while a FIFO holds data
    fifo_empty = 6'b111110; arm = 1; tick(); arm = 0;
    check("arm_refused_busy", int'(busy), 0);
    fifo_empty = '1; arm = 1; tick(); arm = 0; fifo_empty = '0;
    check("arm_accepted_busy", int'(busy), 1);
    // async trigger latency and overflow at sample 5
    adc_valid = 1;
    repeat (2) begin adc_data = {$urandom, $urandom, $urandom}; tick(); end
    trig = 1; rise_edge = edge_cnt + 1; lat_pending = 1;
    adc_data = {$urandom, $urandom, $urandom}; tick();
    adc_data = {$urandom, $urandom, $urandom}; tick();
    trig = 0;
    for (int i = 0; i < 30; i++) begin
      adc_data = {$urandom, $urandom, $urandom};
      fifo_full = (ph == 2 && m_cnt == 5) ? 6'b001000 : '0;
      tick();
    end
    fifo_full = '0; adc_valid = 0;
    check("overflow_flag", int'(overflow), 1);
    check("overflow_count", int'(sample_count), 5);
    check("overflow_full", int'(full), 1);
    check("latency_seen", int'(lat_pending), 0);
    fifo_empty = '1; tick();
    // async reset in the middle of a capture
    start_capture();
    adc_valid = 1;
    for (int i = 0; i < 40 && m_cnt < 10; i++) begin
      adc_data = {$urandom, $urandom, $urandom}; tick();
    end
    #2 rst = 1;
    #1 check("midreset_outputs", int'({fifo_wr_en, fifo_din, full, busy, overflow, sample_count} == '0), 1);
    adc_valid = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    check("after_reset_idle", int'(busy), 0);
    // randomized operation
    for (int k = 0; k < 3000; k++) begin
      arm = ($urandom % 12 == 0);
      force_trig = ($urandom % 20 == 0);
      if ($urandom % 15 == 0) trig = ~trig;
      adc_valid = $urandom % 2;
      adc_data = {$urandom, $urandom, $urandom};
      fifo_full = ($urandom % 40 == 0) ? NCH'(1 << ($urandom % NCH)) : '0;
      fifo_empty = (ph == 3) ? (($urandom % 6 == 0) ? '1 : '0)
                             : (($urandom % 8 == 0) ? NCH'($urandom) : '1);
      tick();
    end
    arm = 0; force_trig = 0; trig = 0; adc_valid = 0; fifo_full = '0; fifo_empty = '1;
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
